// File: rtl/writeback_if.sv
// writeback_if: memory-stage/data-memory inputs and regfile write port of the writeback stage
interface writeback_if;
    logic        clk_en;
    logic [19:0] inst_u_imm_in;
    logic [2:0]  inst_fn3_in;
    logic [4:0]  rd_addr_in;
    logic [2:0]  ctr_in;
    logic [31:0] alu_in;
    logic [29:0] inc_pc_in;
    logic [31:0] mem_data_in;
    logic        mem_valid_in;
    logic        stall;
    logic        load_fault;
    logic        wb_regfile_we;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_data;

    modport slave (
        input  clk_en, inst_u_imm_in, inst_fn3_in, rd_addr_in, ctr_in, alu_in, inc_pc_in,
               mem_data_in, mem_valid_in,
        output stall, load_fault, wb_regfile_we, wb_write_address, wb_data
    );

    modport master (
        output clk_en, inst_u_imm_in, inst_fn3_in, rd_addr_in, ctr_in, alu_in, inc_pc_in,
               mem_data_in, mem_valid_in,
        input  stall, load_fault, wb_regfile_we, wb_write_address, wb_data
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: load alignment, regfile write-source select and load-response wait/timeout FSM
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 16
) (
    input logic        clk,
    input logic        async_rst_n,
    writeback_if.slave wb
);
    localparam int CW = LOAD_TIMEOUT < 2 ? 1 : $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(LOAD_TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   hold, hold_nxt;
    logic          held, held_nxt;
    logic          is_load, timeout_hit;
    logic [31:0]   load_word, load_data, src;
    logic [7:0]    byte_v;
    logic [15:0]   half;

    always_comb begin
        is_load     = wb.ctr_in[0] & (wb.ctr_in[2:1] == 2'b01);
        load_word   = held ? hold : wb.mem_data_in;
        byte_v      = 8'(load_word >> {wb.alu_in[1:0], 3'b000});
        half        = wb.alu_in[1] ? load_word[31:16] : load_word[15:0];
        // fn3[1] selects full word, fn3[0] half vs byte, fn3[2] suppresses sign extension
        load_data   = wb.inst_fn3_in[1] ? load_word :
                      wb.inst_fn3_in[0] ? {{16{~wb.inst_fn3_in[2] & half[15]}}, half} :
                                          {{24{~wb.inst_fn3_in[2] & byte_v[7]}}, byte_v};
        src         = wb.ctr_in[2:1] == 2'b00 ? wb.alu_in :
                      wb.ctr_in[2:1] == 2'b01 ? load_data :
                      wb.ctr_in[2:1] == 2'b10 ? {wb.inst_u_imm_in, 12'h000} :
                                                {wb.inc_pc_in, 2'b00};
        timeout_hit = (state == WAIT) && (LOAD_TIMEOUT != 0) && (cnt == TMAX) && !wb.mem_valid_in;
    end

    assign wb.stall = async_rst_n & ((state == IDLE) ? is_load & wb.clk_en & ~wb.mem_valid_in :
                                     (state == WAIT) ? ~(wb.mem_valid_in | held) & ~timeout_hit :
                                                       1'b0);
    assign wb.wb_regfile_we    = async_rst_n & wb.ctr_in[0] & wb.clk_en & ~wb.stall & (wb.rd_addr_in != 5'd0);
    assign wb.wb_write_address = wb.rd_addr_in;
    assign wb.wb_data          = timeout_hit ? 32'h0 : src;
    assign wb.load_fault       = async_rst_n & timeout_hit;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        held_nxt  = held;
        unique case (state)
            IDLE: if (is_load && wb.clk_en && !wb.mem_valid_in) begin
                state_nxt = WAIT;
                cnt_nxt   = CW'(1);
            end
            WAIT: if (wb.mem_valid_in && wb.clk_en) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (wb.mem_valid_in) begin
                state_nxt = HELD;
                hold_nxt  = wb.mem_data_in;
                held_nxt  = 1'b1;
                cnt_nxt   = '0;
            end else if (timeout_hit) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = (cnt == TMAX) ? cnt : cnt + CW'(1);
            end
            HELD: if (wb.clk_en) begin
                state_nxt = IDLE;
                held_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hold  <= hold_nxt;
            held  <= held_nxt;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized + directed stimulus, per-cycle expectations queued by a
// transaction-level reference model and compared by an independent monitor.
module tb_writeback_stage;
    localparam int T = 4;

    typedef struct packed {
        logic [2:0]  ctr;
        logic [2:0]  fn3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [19:0] uimm;
        logic [29:0] pc;
    } ins_t;

    typedef struct packed {
        logic        stall;
        logic        fault;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic async_rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_if bus();
    writeback_stage #(.LOAD_TIMEOUT(T)) dut (.clk(clk), .async_rst_n(async_rst_n), .wb(bus));

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    bit          pend = 0;
    int          age = 0;
    bit          have = 0;
    logic [31:0] hw = '0;
    bit          advanced = 1;

    function automatic logic [31:0] align(logic [31:0] w, logic [2:0] f, logic [1:0] o);
        int unsigned b, h;
        b = (w >> (8 * o)) % 256;
        h = (w >> (16 * (o / 2))) % 65536;
        case (f)
            3'b000:  return b >= 128 ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return h >= 32768 ? h - 65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic step(input bit rst, input bit ce, input bit vld, input logic [31:0] md, input ins_t ins);
        exp_t e;
        logic [31:0] src;
        bit ld;
        @(posedge clk);
        #1;
        async_rst_n          = ~rst;
        bus.clk_en           = ce;
        bus.mem_valid_in     = vld;
        bus.mem_data_in      = md;
        bus.ctr_in           = ins.ctr;
        bus.inst_fn3_in      = ins.fn3;
        bus.rd_addr_in       = ins.rd;
        bus.alu_in           = ins.alu;
        bus.inst_u_imm_in    = ins.uimm;
        bus.inc_pc_in        = ins.pc;
        e = '0;
        e.addr = ins.rd;
        if (rst) begin
            pend = 0;
            have = 0;
        end else begin
            ld = ins.ctr == 3'b011;
            case (ins.ctr[2:1])
                2'b00:   src = ins.alu;
                2'b10:   src = ins.uimm * 4096;
                2'b11:   src = ins.pc * 4;
                default: src = 0;
            endcase
            if (ld) begin
                if (have) begin
                    src = align(hw, ins.fn3, ins.alu[1:0]);
                    if (ce) have = 0;
                end else if (pend) begin
                    if (vld) begin
                        src  = align(md, ins.fn3, ins.alu[1:0]);
                        pend = 0;
                        if (!ce) begin have = 1; hw = md; end
                    end else if (age == T) begin
                        src     = 0;
                        e.fault = 1;
                        pend    = 0;
                    end else begin
                        e.stall = 1;
                        age++;
                    end
                end else if (vld) begin
                    src = align(md, ins.fn3, ins.alu[1:0]);
                end else if (ce) begin
                    e.stall = 1;
                    pend    = 1;
                    age     = 1;
                end
            end
            e.we   = ins.ctr[0] && ce && !e.stall && ins.rd != 0;
            e.data = src;
        end
        sbq.push_back(e);
        advanced = rst || (ce && !e.stall);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("stall", 32'(bus.stall), 32'(e.stall));
                chk("load_fault", 32'(bus.load_fault), 32'(e.fault));
                chk("we", 32'(bus.wb_regfile_we), 32'(e.we));
                if (e.we) begin
                    chk("addr", 32'(bus.wb_write_address), 32'(e.addr));
                    chk("data", bus.wb_data, e.data);
                end
            end
        end
    end

    function automatic ins_t mk(logic [2:0] ctr, logic [2:0] fn3, logic [4:0] rd, logic [31:0] alu);
        ins_t i;
        i.ctr = ctr; i.fn3 = fn3; i.rd = rd; i.alu = alu;
        i.uimm = 20'hABCDE; i.pc = 30'h0123_4567;
        return i;
    endfunction

    initial begin
        ins_t cur;
        bus.clk_en = 0; bus.mem_valid_in = 0; bus.mem_data_in = 0; bus.ctr_in = 0;
        bus.inst_fn3_in = 0; bus.rd_addr_in = 0; bus.alu_in = 0; bus.inst_u_imm_in = 0; bus.inc_pc_in = 0;
        repeat (2) step(1, 1, 0, 0, mk(3'b001, 0, 5, 0));
        step(0, 1, 0, 0, mk(3'b001, 0, 5, 32'h1234));
        step(0, 1, 1, 32'h80FF_0000, mk(3'b011, 3'b000, 7, 32'h1003));
        repeat (3) step(0, 1, 0, 0, mk(3'b011, 3'b101, 9, 32'h2));
        step(0, 1, 1, 32'hBEEF_0000, mk(3'b011, 3'b101, 9, 32'h2));
        step(0, 1, 0, 0, mk(3'b011, 3'b010, 3, 0));
        step(0, 0, 1, 32'hCAFE_F00D, mk(3'b011, 3'b010, 3, 0));
        step(0, 0, 1, 32'h1111_1111, mk(3'b011, 3'b010, 3, 0));
        step(0, 1, 1, 32'h2222_2222, mk(3'b011, 3'b010, 3, 0));
        repeat (T + 1) step(0, 1, 0, 0, mk(3'b011, 3'b000, 4, 1));
        step(0, 1, 0, 0, mk(3'b111, 0, 0, 0));
        step(0, 1, 0, 0, mk(3'b100, 0, 8, 0));
        step(0, 1, 0, 0, mk(3'b101, 0, 8, 0));
        step(0, 1, 0, 0, mk(3'b000, 0, 8, 0));
        repeat (2) step(0, 1, 0, 0, mk(3'b011, 3'b001, 6, 2));
        step(1, 1, 0, 0, mk(3'b011, 3'b001, 6, 2));
        step(0, 1, 0, 0, mk(3'b001, 0, 6, 32'h55));
        advanced = 1;
        for (int n = 0; n < 2000; n++) begin
            if (advanced) begin
                cur.ctr  = ($urandom_range(0, 2) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
                cur.fn3  = 3'($urandom_range(0, 7));
                cur.rd   = 5'($urandom_range(0, 31));
                cur.alu  = $urandom;
                cur.uimm = 20'($urandom);
                cur.pc   = 30'($urandom);
            end
            step($urandom_range(0, 79) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) < 3, $urandom, cur);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
